stack_file: RTL and testbench

//  Operand-stack storage for the stack processor; sits directly downstream of the stack counter (SC).

---
 rtl/stack_file_if.sv | 28 ++
 rtl/stack_file.sv | 132 +++++++++++++
 tb/tb_stack_file.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_file_if.sv
// Operand-stack port bundle: the SC/ALU side drives the stack, and the stack file returns TOS/NOS and its status flags.
interface stack_file_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
);
  logic [PTR_W-1:0] sc;
  logic [1:0]       op;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic             tos_valid;
  logic             nos_valid;
  logic             ovf;
  logic             unf;
  logic             sync_err;

  modport master (
    output sc, op, wr_en, wr_data, clr_err,
    input  tos, nos, tos_valid, nos_valid, ovf, unf, sync_err
  );

  modport slave (
    input  sc, op, wr_en, wr_data, clr_err,
    output tos, nos, tos_valid, nos_valid, ovf, unf, sync_err
  );
endinterface

// File: rtl/stack_file.sv
// Operand-stack register array behind the stack counter: push/pop/write-back, TOS/NOS read-out,
// sticky overflow/underflow flags and a shadow depth counter that detects SC desynchronisation.
module stack_file #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  stack_file_if.slave  bus
);
  localparam int DEPTH = 2 ** PTR_W;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_DES_2 = 2'b01;
  localparam logic [1:0] OP_DES_1 = 2'b10;
  localparam logic [1:0] OP_ADV_1 = 2'b11;

  localparam logic [PTR_W-1:0] ZERO   = '0;
  localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO    = PTR_W'(2);
  localparam logic [PTR_W-1:0] MAX_SC = '1;

  logic             is_adv;
  logic             is_des1;
  logic             is_des2;
  logic             is_hold;
  logic             ovf_hit;
  logic             unf_hit;
  logic             wr_fire;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] sc_m1;
  logic [PTR_W-1:0] sc_m2;

  logic [PTR_W-1:0] shadow_reg;
  logic [PTR_W-1:0] shadow_next;
  logic             ovf_reg;
  logic             unf_reg;
  logic             sync_err_reg;

  logic [WIDTH-1:0] mem_rd [DEPTH];

  always_comb begin
    is_adv  = (bus.op == OP_ADV_1);
    is_des1 = (bus.op == OP_DES_1);
    is_des2 = (bus.op == OP_DES_2);
    is_hold = (bus.op == OP_HOLD);
    sc_m1   = bus.sc - ONE;
    sc_m2   = bus.sc - TWO;
  end

  // Any illegal access suppresses the write, so the array never sees a wrapped pointer.
  always_comb begin
    ovf_hit = is_adv && (bus.sc == MAX_SC);
    unf_hit = (is_des1 && (bus.sc < ONE))
           || (is_des2 && (bus.sc < TWO))
           || (is_des1 && bus.wr_en && (bus.sc < TWO))
           || (is_hold && bus.wr_en && (bus.sc < ONE));
  end

  always_comb begin
    wr_fire = 1'b0;
    wr_addr = bus.sc;
    if (bus.wr_en && !ovf_hit && !unf_hit) begin
      if (is_adv) begin
        wr_fire = 1'b1;
        wr_addr = bus.sc;
      end else if (is_des1) begin
        wr_fire = 1'b1;
        wr_addr = sc_m2;
      end else if (is_hold) begin
        wr_fire = 1'b1;
        wr_addr = sc_m1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (wr_fire && (wr_addr == PTR_W'(gi))) begin
          entry_reg <= bus.wr_data;
        end
      end

      assign mem_rd[gi] = entry_reg;
    end
  endgenerate

  // Shadow depth mirrors the SC op with saturation at both ends.
  always_comb begin
    shadow_next = shadow_reg;
    if (is_adv) begin
      if (shadow_reg != MAX_SC) shadow_next = shadow_reg + ONE;
    end else if (is_des1) begin
      if (shadow_reg >= ONE) shadow_next = shadow_reg - ONE;
      else                   shadow_next = ZERO;
    end else if (is_des2) begin
      if (shadow_reg >= TWO) shadow_next = shadow_reg - TWO;
      else                   shadow_next = ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg   <= '0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      shadow_reg   <= shadow_next;
      // A fresh error in the same cycle as clr_err keeps the flag set.
      ovf_reg      <= (ovf_reg && !bus.clr_err) || ovf_hit;
      unf_reg      <= (unf_reg && !bus.clr_err) || unf_hit;
      sync_err_reg <= sync_err_reg || (bus.sc != shadow_reg);
    end
  end

  always_comb begin
    bus.tos_valid = (bus.sc >= ONE);
    bus.nos_valid = (bus.sc >= TWO);
    bus.tos       = bus.tos_valid ? mem_rd[sc_m1] : '0;
    bus.nos       = bus.nos_valid ? mem_rd[sc_m2] : '0;
    bus.ovf       = ovf_reg;
    bus.unf       = unf_reg;
    bus.sync_err  = sync_err_reg;
  end
endmodule

// File: tb/tb_stack_file.sv
// Randomized and directed check of stack_file against a depth/array reference model.
module tb_stack_file;
  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_DES_2 = 2'b01;
  localparam logic [1:0] OP_DES_1 = 2'b10;
  localparam logic [1:0] OP_ADV_1 = 2'b11;

  logic clk;
  logic reset;

  stack_file_if #(.WIDTH(8), .PTR_W(4)) bus ();

  stack_file #(.WIDTH(8), .PTR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_mis;

  // Reference state: stack contents, shadow depth and sticky flags.
  logic [7:0] m_mem [16];
  int         m_shadow;
  bit         m_ovf;
  bit         m_unf;
  bit         m_sync;
  int         sc_track;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_depth(input int d, input logic [1:0] o);
    int n;
    n = d;
    case (o)
      OP_ADV_1: n = (d >= 15) ? 15 : d + 1;
      OP_DES_1: n = (d >= 1) ? d - 1 : 0;
      OP_DES_2: n = (d >= 2) ? d - 2 : 0;
      default:  n = d;
    endcase
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_shadow = 0;
    m_ovf    = 0;
    m_unf    = 0;
    m_sync   = 0;
    sc_track = 0;
  endtask

  task automatic model_step(input bit r, input logic [1:0] o, input bit w,
                            input logic [7:0] d, input bit c, input int s);
    bit ovf_set;
    bit unf_set;
    if (r) begin
      model_reset();
      return;
    end
    ovf_set = 0;
    unf_set = 0;
    case (o)
      OP_ADV_1: begin
        if (s == 15) ovf_set = 1;
        else if (w)  m_mem[s] = d;
      end
      OP_DES_1: begin
        if (s < 1 || (w && s < 2)) unf_set = 1;
        else if (w)                m_mem[s-2] = d;
      end
      OP_DES_2: begin
        if (s < 2) unf_set = 1;
      end
      default: begin
        if (w) begin
          if (s < 1) unf_set = 1;
          else       m_mem[s-1] = d;
        end
      end
    endcase
    if (s != m_shadow) m_sync = 1;
    m_shadow = next_depth(m_shadow, o);
    m_ovf    = (m_ovf && !c) || ovf_set;
    m_unf    = (m_unf && !c) || unf_set;
    sc_track = next_depth(sc_track, o);
  endtask

  task automatic check_model();
    int s;
    s = int'(bus.sc);
    check_eq("tos",       32'(bus.tos),       (s >= 1) ? 32'(m_mem[s-1]) : 32'h0);
    check_eq("nos",       32'(bus.nos),       (s >= 2) ? 32'(m_mem[s-2]) : 32'h0);
    check_eq("tos_valid", 32'(bus.tos_valid), (s >= 1) ? 32'h1 : 32'h0);
    check_eq("nos_valid", 32'(bus.nos_valid), (s >= 2) ? 32'h1 : 32'h0);
    check_eq("ovf",       32'(bus.ovf),       32'(m_ovf));
    check_eq("unf",       32'(bus.unf),       32'(m_unf));
    check_eq("sync_err",  32'(bus.sync_err),  32'(m_sync));
  endtask

  // Apply inputs for one cycle and compare the pre-edge outputs with the model.
  task automatic drive(input bit r, input logic [1:0] o, input bit w,
                       input logic [7:0] d, input bit c, input logic [3:0] s);
    reset       = r;
    bus.op      = o;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.clr_err = c;
    bus.sc      = s;
    #1;
    check_model();
  endtask

  task automatic advance();
    bit r;
    logic [1:0] o;
    bit w;
    logic [7:0] d;
    bit c;
    int s;
    r = reset;
    o = bus.op;
    w = bus.wr_en;
    d = bus.wr_data;
    c = bus.clr_err;
    s = int'(bus.sc);
    @(posedge clk);
    model_step(r, o, w, d, c, s);
    #1;
    $display("cyc r=%0b op=%0d we=%0b d=%02h clr=%0b sc=%0d -> tos=%02h nos=%02h ovf=%0b unf=%0b sync=%0b",
             r, o, w, d, c, s, bus.tos, bus.nos, bus.ovf, bus.unf, bus.sync_err);
  endtask

  task automatic do_reset();
    drive(1'b1, OP_ADV_1, 1'b1, 8'hEE, 1'b0, 4'd0);
    advance();
    drive(1'b1, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    advance();
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b0, OP_ADV_1, 1'b1, d, 1'b0, 4'(sc_track));
    advance();
  endtask

  task automatic push_three();
    do_reset();
    push(8'h11);
    push(8'h22);
    push(8'h33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] o;
    bit w;
    bit c;
    bit r;
    logic [3:0] s;
    int k;

    n_cmp = 0;
    n_mis = 0;
    model_reset();
    reset       = 1'b1;
    bus.op      = OP_HOLD;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_err = 1'b0;
    bus.sc      = 4'd0;
    @(posedge clk);
    #1;

    do_reset();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    check_eq("rst_flags", {29'h0, bus.ovf, bus.unf, bus.sync_err}, 32'h0);

    // 1: three pushes
    push_three();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd3);
    check_eq("t1_tos", 32'(bus.tos), 32'h33);
    check_eq("t1_nos", 32'(bus.nos), 32'h22);
    check_eq("t1_val", {30'h0, bus.tos_valid, bus.nos_valid}, 32'h3);

    // 2: binary op write-back
    drive(1'b0, OP_DES_1, 1'b1, 8'h55, 1'b0, 4'd3);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd2);
    check_eq("t2_tos", 32'(bus.tos), 32'h55);
    check_eq("t2_nos", 32'(bus.nos), 32'h11);

    // 3: pop two
    push_three();
    drive(1'b0, OP_DES_2, 1'b0, 8'h00, 1'b0, 4'd3);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd1);
    check_eq("t3_tos", 32'(bus.tos), 32'h11);
    check_eq("t3_nosv", 32'(bus.nos_valid), 32'h0);
    check_eq("t3_nos", 32'(bus.nos), 32'h0);

    // 4: underflow, clear, and clear racing a new underflow
    do_reset();
    drive(1'b0, OP_DES_1, 1'b0, 8'h00, 1'b0, 4'd0);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b1, 4'd0);
    check_eq("t4_unf_set", 32'(bus.unf), 32'h1);
    advance();
    drive(1'b0, OP_ADV_1, 1'b1, 8'h44, 1'b0, 4'd0);
    check_eq("t4_unf_clr", 32'(bus.unf), 32'h0);
    advance();
    drive(1'b0, OP_DES_2, 1'b0, 8'h00, 1'b1, 4'd1);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    check_eq("t4_unf_win", 32'(bus.unf), 32'h1);
    check_eq("t4_sync", 32'(bus.sync_err), 32'h0);

    // 5: overflow at depth 15, then desync
    do_reset();
    for (int i = 0; i < 15; i++) push(8'(8'h80 + i));
    drive(1'b0, OP_ADV_1, 1'b1, 8'hAA, 1'b0, 4'd15);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd15);
    check_eq("t5_ovf", 32'(bus.ovf), 32'h1);
    check_eq("t5_tos", 32'(bus.tos), 32'h8E);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    check_eq("t5_sync", 32'(bus.sync_err), 32'h1);

    // 6: reset wins over a simultaneous push
    push_three();
    drive(1'b1, OP_ADV_1, 1'b1, 8'h77, 1'b0, 4'd3);
    advance();
    drive(1'b0, OP_HOLD, 1'b0, 8'h00, 1'b0, 4'd1);
    check_eq("t6_tos", 32'(bus.tos), 32'h00);
    check_eq("t6_flags", {29'h0, bus.ovf, bus.unf, bus.sync_err}, 32'h0);

    // Random traffic with the SC tracked consistently, then with occasional desync.
    do_reset();
    for (int n = 0; n < 900; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 3)      o = OP_ADV_1;
      else if (k <= 5) o = OP_DES_1;
      else if (k == 6) o = OP_DES_2;
      else             o = OP_HOLD;
      w = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 99) == 0);
      s = 4'(sc_track);
      if (n >= 600 && $urandom_range(0, 39) == 0) s = 4'($urandom_range(0, 15));
      drive(r, o, w, 8'($urandom), c, s);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
